// File: rtl/bram_arb_pkg.sv
// Shared constants, state type and sizing helper for the BRAM port arbiter.
package bram_arb_pkg;

  localparam int BRAM_WE_W   = 4;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Width of an index/counter able to hold 0..n-1, never below one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_rr_pick.sv
// Rotating-priority picker: first set request after ptr_i, wrapping, with ptr_i itself scanned last.
module bram_rr_pick
  import bram_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IW-1:0]      idx_o
);

  always_comb begin
    int   cand;
    logic found;
    cand   = 0;
    found  = 1'b0;
    pick_o = '0;
    idx_o  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        pick_o[cand] = 1'b1;
        idx_o        = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters, with burst lock and tagged read return.
// Define BRAM_ARB_PRIO0_EN to let requester 0 win whenever the current owner is not lock-held.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int RD_LATENCY = 2,
  parameter  int MAX_LOCK   = 64,
  localparam int IW         = idx_width(NUM_REQ),
  localparam int CW         = idx_width(MAX_LOCK)
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wrdata,
  input  logic [NUM_REQ*BRAM_WE_W-1:0]    we,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]           rddata,
  output logic [ADDR_WIDTH-1:0]           BRAM_ADDR,
  output logic [DATA_WIDTH-1:0]           BRAM_WRDATA,
  output logic [BRAM_WE_W-1:0]            BRAM_WE,
  output logic                            BRAM_EN,
  output logic                            BRAM_CLK,
  input  logic [DATA_WIDTH-1:0]           BRAM_RDDATA,
  output logic                            dbg_state_o
);

  // Handshake: a beat is accepted in any cycle where req[i] and gnt[i] are both high;
  // the requester holds addr/wrdata/we stable while req is high and the arbiter samples them then.

  arb_state_e          state_q;
  logic [IW-1:0]       ptr_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [CW-1:0]       lock_cnt_q;
  logic [RD_LATENCY-1:0] rd_v_q;
  logic [IW-1:0]       rd_idx_q [RD_LATENCY];

  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wrdata;
  logic [BRAM_WE_W-1:0]  own_we;
  logic                  accept;
  logic                  keep_own;
  logic [NUM_REQ-1:0]    rr_oh;
  logic [IW-1:0]         rr_idx;
  logic [NUM_REQ-1:0]    win_oh;
  logic [IW-1:0]         win_idx;

  always_comb begin
    own_addr   = '0;
    own_wrdata = '0;
    own_we     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ptr_q == IW'(i)) begin
        own_addr   = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_wrdata = wrdata[i*DATA_WIDTH +: DATA_WIDTH];
        own_we     = we[i*BRAM_WE_W +: BRAM_WE_W];
      end
    end
  end

  assign accept      = |(req & gnt_q);
  assign BRAM_EN     = accept;
  assign BRAM_WE     = accept ? own_we : '0;
  assign BRAM_ADDR   = own_addr;
  assign BRAM_WRDATA = own_wrdata;
  assign BRAM_CLK    = aclk;
  assign rddata      = BRAM_RDDATA;
  assign gnt         = gnt_q;
  assign dbg_state_o = (state_q == OWN);

  assign keep_own = (state_q == OWN) && req[ptr_q] && lock[ptr_q] &&
                    (lock_cnt_q < CW'(MAX_LOCK - 1));

  bram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (rr_oh),
    .idx_o  (rr_idx)
  );

  always_comb begin
    win_oh  = rr_oh;
    win_idx = rr_idx;
`ifdef BRAM_ARB_PRIO0_EN
    if (req[0]) begin
      win_oh  = NUM_REQ'(1);
      win_idx = '0;
    end
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(NUM_REQ - 1);
      gnt_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= OWN;
            gnt_q   <= win_oh;
            ptr_q   <= win_idx;
          end
          lock_cnt_q <= '0;
        end
        OWN: begin
          if (keep_own) begin
            lock_cnt_q <= lock_cnt_q + CW'(1);
          end else if (|req) begin
            gnt_q      <= win_oh;
            ptr_q      <= win_idx;
            lock_cnt_q <= '0;
          end else begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            lock_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= IDLE;
          gnt_q      <= '0;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  // Read tags travel alongside the BRAM pipeline so each return lands on its issuer.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_v_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) rd_idx_q[s] <= '0;
    end else begin
      rd_v_q[0]   <= accept && (own_we == '0);
      rd_idx_q[0] <= ptr_q;
      for (int s = 1; s < RD_LATENCY; s++) begin
        rd_v_q[s]   <= rd_v_q[s-1];
        rd_idx_q[s] <= rd_idx_q[s-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (rd_v_q[RD_LATENCY-1]) rvalid[rd_idx_q[RD_LATENCY-1]] = 1'b1;
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios plus random traffic against a spec-level grant/memory model.
module tb_bram_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int L  = 2;
  localparam int ML = 64;
  localparam int W  = 72;

  logic          aclk = 1'b0;
  logic          areset;
  logic [N-1:0]  req, lock, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wrdata;
  logic [N*4-1:0]  we;
  logic [DW-1:0] rddata, BRAM_WRDATA, BRAM_RDDATA;
  logic [AW-1:0] BRAM_ADDR;
  logic [3:0]    BRAM_WE;
  logic          BRAM_EN, BRAM_CLK, dbg_state;

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  int en_cnt = 0;

  // Reference model state
  int m_owner, m_ptr, m_cnt;
  logic [31:0] ref_mem [0:255];
  logic [W-1:0] exp_q[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  bram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(L), .MAX_LOCK(ML)) dut (
    .aclk(aclk), .areset(areset), .req(req), .lock(lock), .addr(addr), .wrdata(wrdata), .we(we),
    .gnt(gnt), .rvalid(rvalid), .rddata(rddata), .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA),
    .BRAM_WE(BRAM_WE), .BRAM_EN(BRAM_EN), .BRAM_CLK(BRAM_CLK), .BRAM_RDDATA(BRAM_RDDATA),
    .dbg_state_o(dbg_state)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Two-stage BRAM stand-in: data for a beat accepted in cycle c appears in cycle c+2.
  logic [31:0]  mem [0:255];
  logic [255:0] wr_mask = '0;
  logic [31:0]  rd1, rd2;
  always @(posedge BRAM_CLK) begin : bram_model
    logic [31:0] cur;
    cur = wr_mask[BRAM_ADDR[7:0]] ? mem[BRAM_ADDR[7:0]] : init_word(int'(BRAM_ADDR[7:0]));
    if (BRAM_EN) begin
      rd1 <= cur;
      for (int b = 0; b < 4; b++) if (BRAM_WE[b]) cur[b*8 +: 8] = BRAM_WRDATA[b*8 +: 8];
      if (BRAM_WE != 4'h0) begin
        mem[BRAM_ADDR[7:0]]     <= cur;
        wr_mask[BRAM_ADDR[7:0]] <= 1'b1;
      end
    end
    rd2 <= rd1;
  end
  assign BRAM_RDDATA = rd2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic note_fail(input string name, input string msg);
    n_checks++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_cnt   = 0;
  endtask

  // Called just after a rising edge with inputs already driven for this cycle.
  task automatic run_cycle();
    logic [3:0]  ow;
    logic [31:0] oa, od;
    bit          acc;
    int          nxt;
    ow = '0; oa = '0; od = '0;
    #1;
    acc = (m_owner >= 0) && (req[m_owner] == 1'b1);
    if (m_owner >= 0) begin
      ow = we[m_owner*4 +: 4];
      oa = addr[m_owner*AW +: AW];
      od = wrdata[m_owner*DW +: DW];
    end
    if (BRAM_EN === 1'b1) en_cnt++;
    chk("bram_en", BRAM_EN, acc);
    chk("bram_we", BRAM_WE, acc ? ow : 4'h0);
    if (acc) begin
      chk("bram_addr", BRAM_ADDR, oa);
      if (ow != 4'h0) begin
        chk("bram_wrdata", BRAM_WRDATA, od);
        for (int b = 0; b < 4; b++) if (ow[b]) ref_mem[oa[7:0]][b*8 +: 8] = od[b*8 +: 8];
      end else begin
        exp_q.push_back({32'(cyc + L), 8'(m_owner), ref_mem[oa[7:0]]});
      end
    end
    if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_cnt < ML - 1) begin
      m_cnt++;
    end else begin
      nxt = -1;
      for (int k = 1; k <= N; k++) if (nxt < 0 && req[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
`ifdef BRAM_ARB_PRIO0_EN
      if (req[0]) nxt = 0;
`endif
      m_cnt   = 0;
      m_owner = nxt;
      if (nxt >= 0) m_ptr = nxt;
    end
    @(posedge aclk);
    #1;
    chk("gnt", gnt, (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
    chk("state", dbg_state, m_owner >= 0);
  endtask

  task automatic single_beat(input int i, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    bit done;
    done = 1'b0;
    req = '0; lock = '0;
    req[i] = 1'b1;
    addr[i*AW +: AW] = a;
    we[i*4 +: 4]     = w;
    wrdata[i*DW +: DW] = d;
    for (int t = 0; t < 20 && !done; t++) begin
      done = (m_owner == i);
      run_cycle();
    end
    if (!done) note_fail("beat_timeout", $sformatf("requester %0d never granted", i));
  endtask

  // Monitor: pops the expected read returns whenever the DUT strobes rvalid.
  always @(negedge aclk) begin : monitor
    logic [W-1:0] e;
    if (areset === 1'b1) begin
      if (rvalid !== '0) note_fail("rvalid_in_reset", $sformatf("rvalid=%b", rvalid));
      exp_q.delete();
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q[0];
        if (int'(e[71:40]) < cyc) begin
          note_fail("rvalid_missing", $sformatf("requester %0d due cycle %0d", e[39:32], e[71:40]));
          void'(exp_q.pop_front());
        end else break;
      end
      if (rvalid !== '0) begin
        if (exp_q.size() == 0) begin
          note_fail("rvalid_unexpected", $sformatf("rvalid=%b cycle %0d", rvalid, cyc));
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_cycle", 64'(cyc), 64'(e[71:40]));
          chk("rvalid_idx", rvalid, 64'd1 << e[39:32]);
          chk("rddata", rddata, e[31:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int maxrun, run;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    areset = 1'b1;
    req = '0; lock = '0; addr = '0; wrdata = '0; we = '0;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_en", BRAM_EN, 0);
    chk("rst_we", BRAM_WE, 0);
    chk("rst_state", dbg_state, 0);
    areset = 1'b0;

    // Fairness: all four requesting, no lock
    req = 4'b1111;
    run_cycle();
    for (int k = 0; k < 8; k++) begin
      chk("fair_order", gnt, 64'd1 << (k % 4));
      run_cycle();
    end
    req = '0;
    run_cycle();

    // Sole requester streams four reads back to back
    en_cnt = 0;
    req = 4'b0001;
    addr[0 +: AW] = 32'h10;
    run_cycle();
    for (int k = 0; k < 4; k++) begin
      addr[0 +: AW] = 32'h10 + 32'(k);
      run_cycle();
    end
    chk("single_beats", en_cnt, 4);
    req = '0;
    repeat (L + 1) run_cycle();

    // Burst lock with a competing requester
    req = 4'b0110; lock = 4'b0010;
    addr[1*AW +: AW] = 32'h40; addr[2*AW +: AW] = 32'h50;
    we = '0;
    maxrun = 0; run = 0;
    for (int k = 0; k < 100; k++) begin
      run_cycle();
      if (gnt == 4'b0010) run++; else run = 0;
      if (run > maxrun) maxrun = run;
    end
    chk("burst_run", maxrun, ML);
    req = 4'b0010;
    repeat (3) run_cycle();
    chk("burst_return", gnt, 4'b0010);
    req = '0; lock = '0;
    repeat (L + 1) run_cycle();

    // Write then read back from another requester
    single_beat(2, 32'h20, 4'hF, 32'hDEAD_BEEF);
    single_beat(3, 32'h20, 4'h0, 32'h0);
    req = '0;
    repeat (L + 2) run_cycle();

    // Requester 0 arriving while others are served
    req = 4'b1110;
    for (int t = 0; t < 10 && m_owner != 3; t++) run_cycle();
    req = 4'b1111;
    run_cycle();
    chk("prio_from3", gnt, 4'b0001);
    req = 4'b1110;
    for (int t = 0; t < 10 && m_owner != 1; t++) run_cycle();
    req = 4'b1111;
    run_cycle();
    req = '0;
    repeat (L + 1) run_cycle();

    // Reset with a read in flight
    single_beat(1, 32'h30, 4'h0, 32'h0);
    req = 4'b1100; lock = '0;
    we = '0;
    areset = 1'b1;
    #1;
    chk("rst_mid_gnt", gnt, 0);
    chk("rst_mid_en", BRAM_EN, 0);
    chk("rst_mid_we", BRAM_WE, 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    run_cycle();
    chk("first_after_rst", gnt, 4'b0100);
    req = '0;
    repeat (L + 1) run_cycle();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      req  = N'($urandom_range(0, 15));
      lock = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW]   = 32'($urandom_range(0, 15)) + 32'h80;
        wrdata[i*DW +: DW] = $urandom;
        we[i*4 +: 4]       = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      run_cycle();
    end

    req = '0; lock = '0;
    repeat (L + 4) run_cycle();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
